// File: rtl/riscv_branch_predictor.sv
// gshare direction predictor: 2-bit saturating counters indexed by PC ^ GHR,
// trained non-speculatively from execute. Optional perf counters under RISCV_BP_PERF_EN.
module riscv_branch_predictor #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned IDX_W = 6,
    parameter int unsigned GHR_W = 6
) (
    input  logic             i_riscv_clk,
    input  logic             i_riscv_rst,
    input  logic [XLEN-1:0]  i_riscv_bp_fetch_pc,
    output logic             o_riscv_bp_predict_taken,
    output logic [IDX_W-1:0] o_riscv_bp_fetch_index,
    input  logic             i_riscv_bp_resolve_valid,
    input  logic [IDX_W-1:0] i_riscv_bp_resolve_index,
    input  logic             i_riscv_bp_resolve_pred,
    input  logic             i_riscv_bp_resolve_taken,
    input  logic             i_riscv_bp_stall,
    output logic             o_riscv_bp_mispredict,
    output logic [31:0]      o_riscv_bp_branch_cnt,
    output logic [31:0]      o_riscv_bp_mispred_cnt
);

    localparam int unsigned ENTRIES = 2 ** IDX_W;

    logic [1:0]       table_q [ENTRIES];
    logic [GHR_W-1:0] ghr_q;
    logic [GHR_W-1:0] ghr_d;
    logic             upd;
    logic [1:0]       cnt_cur;
    logic [1:0]       cnt_nxt;
    logic [IDX_W-1:0] fetch_idx;
    logic             unused_pc_bits;

    assign upd = i_riscv_bp_resolve_valid & ~i_riscv_bp_stall;

    // Fetch lookup reads pre-update table state; no write bypass.
    assign fetch_idx                = i_riscv_bp_fetch_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
    assign o_riscv_bp_fetch_index   = fetch_idx;
    assign o_riscv_bp_predict_taken = table_q[fetch_idx][1];
    assign o_riscv_bp_mispredict    = upd & ~i_riscv_rst &
                                      (i_riscv_bp_resolve_pred ^ i_riscv_bp_resolve_taken);

    assign unused_pc_bits = ^{i_riscv_bp_fetch_pc[XLEN-1:IDX_W+2], i_riscv_bp_fetch_pc[1:0]};

    // Saturating counter update for the resolving entry.
    always_comb begin
        cnt_cur = table_q[i_riscv_bp_resolve_index];
        cnt_nxt = cnt_cur;
        if (i_riscv_bp_resolve_taken) begin
            if (cnt_cur != 2'b11) cnt_nxt = cnt_cur + 2'd1;
        end else begin
            if (cnt_cur != 2'b00) cnt_nxt = cnt_cur - 2'd1;
        end
    end

    generate
        if (GHR_W == 1) begin : g_ghr1
            assign ghr_d = i_riscv_bp_resolve_taken;
        end else begin : g_ghrn
            assign ghr_d = {ghr_q[GHR_W-2:0], i_riscv_bp_resolve_taken};
        end
    endgenerate

    always_ff @(posedge i_riscv_clk or posedge i_riscv_rst) begin
        if (i_riscv_rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                table_q[i] <= 2'b01;
            end
            ghr_q <= '0;
        end else if (upd) begin
            table_q[i_riscv_bp_resolve_index] <= cnt_nxt;
            ghr_q                             <= ghr_d;
        end
    end

`ifdef RISCV_BP_PERF_EN
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd && branch_cnt_q != 32'hFFFF_FFFF) branch_cnt_d = branch_cnt_q + 32'd1;
        if (o_riscv_bp_mispredict && mispred_cnt_q != 32'hFFFF_FFFF) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge i_riscv_clk or posedge i_riscv_rst) begin
        if (i_riscv_rst) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign o_riscv_bp_branch_cnt  = branch_cnt_q;
    assign o_riscv_bp_mispred_cnt = mispred_cnt_q;
`else
    assign o_riscv_bp_branch_cnt  = 32'd0;
    assign o_riscv_bp_mispred_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_riscv_branch_predictor.sv
// Directed self-checking bench for riscv_branch_predictor (default parameters).
module tb_riscv_branch_predictor;

`ifdef RISCV_BP_PERF_EN
    localparam logic [31:0] EXP_BR = 32'd10;
    localparam logic [31:0] EXP_MP = 32'd4;
`else
    localparam logic [31:0] EXP_BR = 32'd0;
    localparam logic [31:0] EXP_MP = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc;
    logic        pred_taken;
    logic [5:0]  fidx;
    logic        rv;
    logic [5:0]  ridx;
    logic        rpred;
    logic        rtaken;
    logic        stall;
    logic        mis;
    logic [31:0] bcnt;
    logic [31:0] mcnt;

    int checks = 0;
    int errors = 0;

    riscv_branch_predictor dut (
        .i_riscv_clk              (clk),
        .i_riscv_rst              (rst),
        .i_riscv_bp_fetch_pc      (pc),
        .o_riscv_bp_predict_taken (pred_taken),
        .o_riscv_bp_fetch_index   (fidx),
        .i_riscv_bp_resolve_valid (rv),
        .i_riscv_bp_resolve_index (ridx),
        .i_riscv_bp_resolve_pred  (rpred),
        .i_riscv_bp_resolve_taken (rtaken),
        .i_riscv_bp_stall         (stall),
        .o_riscv_bp_mispredict    (mis),
        .o_riscv_bp_branch_cnt    (bcnt),
        .o_riscv_bp_mispred_cnt   (mcnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_res(input logic v, input logic [5:0] idx, input logic p, input logic t);
        rv     = v;
        ridx   = idx;
        rpred  = p;
        rtaken = t;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        stall = 1'b0;
        set_res(1'b0, 6'd0, 1'b0, 1'b0);
        #2;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        pc = 64'h0;
        do_reset();

        // Reset state
        chk("rst_pred", 64'(pred_taken), 64'd0);
        chk("rst_idx",  64'(fidx),       64'd0);
        chk("rst_mis",  64'(mis),        64'd0);
        chk("rst_bcnt", 64'(bcnt),       64'd0);
        chk("rst_mcnt", 64'(mcnt),       64'd0);

        // Train idx 5 taken twice from WNT
        pc = 64'h14;
        set_res(1'b1, 6'd5, 1'b0, 1'b1);
        #1;
        chk("t2_idx0",  64'(fidx),       64'd5);
        chk("t2_pred0", 64'(pred_taken), 64'd0);
        chk("t2_mis0",  64'(mis),        64'd1);
        step();
        chk("t2_mis1",  64'(mis),        64'd1);
        step();
        set_res(1'b0, 6'd0, 1'b0, 1'b0);
        pc = 64'h18;
        #1;
        chk("t2_idx2",  64'(fidx),       64'd5);
        chk("t2_pred2", 64'(pred_taken), 64'd1);

        // High saturation at idx 3
        do_reset();
        set_res(1'b1, 6'd3, 1'b1, 1'b1);
        repeat (4) step();
        set_res(1'b0, 6'd0, 1'b0, 1'b0);
        pc = 64'h30;
        #1;
        chk("sat_hi_idx",  64'(fidx),       64'd3);
        chk("sat_hi_pred", 64'(pred_taken), 64'd1);
        set_res(1'b1, 6'd3, 1'b1, 1'b0);
        step();
        set_res(1'b0, 6'd0, 1'b0, 1'b0);
        pc = 64'h74;
        #1;
        chk("sat_nt1_idx",  64'(fidx),       64'd3);
        chk("sat_nt1_pred", 64'(pred_taken), 64'd1);
        set_res(1'b1, 6'd3, 1'b1, 1'b0);
        step();
        set_res(1'b0, 6'd0, 1'b0, 1'b0);
        pc = 64'hFC;
        #1;
        chk("sat_nt2_idx",  64'(fidx),       64'd3);
        chk("sat_nt2_pred", 64'(pred_taken), 64'd0);

        // Low saturation at idx 9: GHR stays 0 while only not-taken resolves
        do_reset();
        pc = 64'h24;
        set_res(1'b1, 6'd9, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("sat_lo_idx",  64'(fidx),       64'd9);
            chk("sat_lo_pred", 64'(pred_taken), 64'd0);
        end
        set_res(1'b1, 6'd9, 1'b0, 1'b1);
        step();
        set_res(1'b0, 6'd0, 1'b0, 1'b0);
        pc = 64'h20;
        #1;
        chk("sat_lo_up_idx",  64'(fidx),       64'd9);
        chk("sat_lo_up_pred", 64'(pred_taken), 64'd0);

        // Stall holds the update until stall drops
        do_reset();
        pc    = 64'h1C;
        stall = 1'b1;
        set_res(1'b1, 6'd7, 1'b0, 1'b1);
        #1;
        chk("stl_mis0", 64'(mis), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stl_mis",  64'(mis),        64'd0);
            chk("stl_idx",  64'(fidx),       64'd7);
            chk("stl_pred", 64'(pred_taken), 64'd0);
        end
        stall = 1'b0;
        #1;
        chk("stl_mis_rel", 64'(mis), 64'd1);
        step();
        set_res(1'b0, 6'd0, 1'b0, 1'b0);
        pc = 64'h18;
        #1;
        chk("stl_post_idx",  64'(fidx),       64'd7);
        chk("stl_post_pred", 64'(pred_taken), 64'd1);
        pc = 64'h0;
        #1;
        chk("stl_ghr_once", 64'(fidx), 64'd1);
        set_res(1'b1, 6'd7, 1'b1, 1'b0);
        #1;
        chk("stl_nt_mis", 64'(mis), 64'd1);
        step();
        set_res(1'b0, 6'd0, 1'b0, 1'b0);
        pc = 64'h14;
        #1;
        chk("stl_once_idx",  64'(fidx),       64'd7);
        chk("stl_once_pred", 64'(pred_taken), 64'd0);

        // GHR indexing and same-cycle read/write without bypass
        do_reset();
        set_res(1'b1, 6'd0, 1'b1, 1'b1);
        #1;
        chk("ghr_mis_ok", 64'(mis), 64'd0);
        step();
        step();
        set_res(1'b0, 6'd0, 1'b0, 1'b0);
        pc = 64'h0;
        #1;
        chk("ghr_idx3",  64'(fidx),       64'd3);
        chk("ghr_pred3", 64'(pred_taken), 64'd0);
        set_res(1'b1, 6'd3, 1'b0, 1'b1);
        #1;
        chk("same_pred", 64'(pred_taken), 64'd0);
        chk("same_mis",  64'(mis),        64'd1);
        step();
        set_res(1'b0, 6'd0, 1'b0, 1'b0);
        #1;
        chk("same_nidx", 64'(fidx), 64'd7);
        pc = 64'h10;
        #1;
        chk("same_new_idx",  64'(fidx),       64'd3);
        chk("same_new_pred", 64'(pred_taken), 64'd1);

        // Perf counters: 10 resolves, first 4 mispredicted, plus ignored cycles
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_res(1'b1, 6'd2, (i < 4) ? 1'b0 : 1'b1, 1'b1);
            #1;
            chk("perf_mis", 64'(mis), (i < 4) ? 64'd1 : 64'd0);
            step();
        end
        stall = 1'b1;
        set_res(1'b1, 6'd2, 1'b0, 1'b1);
        step();
        stall = 1'b0;
        set_res(1'b0, 6'd2, 1'b0, 1'b1);
        #1;
        chk("perf_mis_inv", 64'(mis), 64'd0);
        step();
        pc = 64'hF4;
        #1;
        chk("perf_idx",  64'(fidx),       64'd2);
        chk("perf_pred", 64'(pred_taken), 64'd1);
        chk("perf_bcnt", 64'(bcnt),       64'(EXP_BR));
        chk("perf_mcnt", 64'(mcnt),       64'(EXP_MP));

        // Asynchronous reset mid-cycle clears everything at once
        #3;
        set_res(1'b1, 6'd2, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        chk("arst_mis",  64'(mis),        64'd0);
        chk("arst_idx",  64'(fidx),       64'd61);
        chk("arst_pred", 64'(pred_taken), 64'd0);
        chk("arst_bcnt", 64'(bcnt),       64'd0);
        chk("arst_mcnt", 64'(mcnt),       64'd0);
        pc = 64'h8;
        #1;
        chk("arst_tbl_idx",  64'(fidx),       64'd2);
        chk("arst_tbl_pred", 64'(pred_taken), 64'd0);
        set_res(1'b0, 6'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
